event_encoder16: RTL and testbench

- Sequential 16-to-4 encoder; the inverse of the 4-to-16 decoder used in the same design.
- Captures single-cycle event pulses on 16 request lines into a sticky pending register.
- Presents one pending index at a time as a 4-bit code {a,b,c,d} under a valid/ready handshake.
- Feeding a,b,c,d into the decoder asserts out<index>, so the two blocks round-trip.

---
 rtl/event_encoder16.sv | 118 +++++++++++
 tb/tb_event_encoder16.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/event_encoder16.sv
// Sequential 16-to-4 event encoder: sticky pending register, priority pick,
// valid/ready presentation of one index at a time, plus overflow tracking.
module event_encoder16 #(
    parameter bit LOW_FIRST = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] req,
    input  logic        ready,
    input  logic        ovf_clr,
    output logic        valid,
    output logic        a,
    output logic        b,
    output logic        c,
    output logic        d,
    output logic [4:0]  pend_cnt,
    output logic        overflow
);

    typedef enum logic [0:0] {StIdle, StHold} state_e;

    state_e      r_state;
    state_e      w_state_next;
    logic [15:0] r_pending;
    logic [15:0] w_pending_next;
    logic [3:0]  r_code;
    logic [3:0]  w_code_next;
    logic [4:0]  r_cnt;
    logic        r_ovf;
    logic        w_ovf_next;

    logic        w_accept;
    logic [15:0] w_clr_mask;
    logic [15:0] w_rest;
    logic        w_ovf_set;

    // First set bit in the configured scan direction; 0 when x is empty.
    function automatic logic [3:0] prio(input logic [15:0] x);
        logic [3:0] idx;
        idx = '0;
        if (LOW_FIRST) begin
            for (int i = 15; i >= 0; i--) begin
                if (x[i]) idx = 4'(i);
            end
        end else begin
            for (int i = 0; i < 16; i++) begin
                if (x[i]) idx = 4'(i);
            end
        end
        return idx;
    endfunction

    function automatic logic [4:0] popcount(input logic [15:0] x);
        logic [4:0] n;
        n = '0;
        for (int i = 0; i < 16; i++) begin
            n = n + {4'b0000, x[i]};
        end
        return n;
    endfunction

    assign w_accept       = (r_state == StHold) && ready;
    assign w_clr_mask     = w_accept ? (16'h0001 << r_code) : 16'h0000;
    assign w_rest         = r_pending & ~w_clr_mask;
    // A new req on the bit being accepted re-arms it; only untouched pending bits overflow.
    assign w_pending_next = w_rest | req;
    assign w_ovf_set      = |(req & w_rest);
    assign w_ovf_next     = w_ovf_set ? 1'b1 : (ovf_clr ? 1'b0 : r_ovf);

    always_comb begin
        w_state_next = r_state;
        w_code_next  = r_code;
        case (r_state)
            StIdle: begin
                if (r_pending != 16'h0000) begin
                    w_code_next  = prio(r_pending);
                    w_state_next = StHold;
                end
            end
            StHold: begin
                // Same-cycle req bits are excluded so they never preempt a transfer.
                if (ready) begin
                    if (w_rest != 16'h0000) begin
                        w_code_next = prio(w_rest);
                    end else begin
                        w_state_next = StIdle;
                    end
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= StIdle;
            r_pending <= '0;
            r_code    <= '0;
            r_cnt     <= '0;
            r_ovf     <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_pending <= w_pending_next;
            r_code    <= w_code_next;
            r_cnt     <= popcount(w_pending_next);
            r_ovf     <= w_ovf_next;
        end
    end

    assign valid    = (r_state == StHold);
    assign a        = r_code[3];
    assign b        = r_code[2];
    assign c        = r_code[1];
    assign d        = r_code[0];
    assign pend_cnt = r_cnt;
    assign overflow = r_ovf;

endmodule

// File: tb/tb_event_encoder16.sv
// Randomized and directed bench for event_encoder16 against a set-based
// reference model of pending events, presentation order and overflow.
module tb_event_encoder16;

    localparam bit LOW_FIRST = 1'b1;

    logic        clk;
    logic        rst_n;
    logic [15:0] req;
    logic        ready;
    logic        ovf_clr;
    logic        valid;
    logic        a;
    logic        b;
    logic        c;
    logic        d;
    logic [4:0]  pend_cnt;
    logic        overflow;

    int n_checks;
    int n_errors;

    // Reference model state
    bit m_pend [16];
    bit m_valid;
    int m_code;
    bit m_ovf;

    event_encoder16 #(
        .LOW_FIRST(LOW_FIRST)
    ) u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .ready   (ready),
        .ovf_clr (ovf_clr),
        .valid   (valid),
        .a       (a),
        .b       (b),
        .c       (c),
        .d       (d),
        .pend_cnt(pend_cnt),
        .overflow(overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int pick(input bit s [16]);
        int idx;
        idx = -1;
        for (int k = 0; k < 16; k++) begin
            int i;
            i = LOW_FIRST ? k : 15 - k;
            if (s[i] && idx < 0) idx = i;
        end
        return idx;
    endfunction

    function automatic int count(input bit s [16]);
        int n;
        n = 0;
        foreach (s[i]) n += int'(s[i]);
        return n;
    endfunction

    task automatic model_reset();
        foreach (m_pend[i]) m_pend[i] = 1'b0;
        m_valid = 1'b0;
        m_code  = 0;
        m_ovf   = 1'b0;
    endtask

    task automatic model_step(input logic [15:0] rq, input logic rd, input logic oc);
        bit old  [16];
        bit rest [16];
        bit lost;
        bit taken;
        old  = m_pend;
        lost = 1'b0;
        for (int i = 0; i < 16; i++) begin
            taken   = m_valid && rd && (i == m_code);
            rest[i] = old[i] && !taken;
            if (rq[i] && rest[i]) lost = 1'b1;
            m_pend[i] = rest[i] || rq[i];
        end
        if (!m_valid) begin
            if (pick(old) >= 0) begin
                m_code  = pick(old);
                m_valid = 1'b1;
            end
        end else if (rd) begin
            if (pick(rest) >= 0) m_code = pick(rest);
            else m_valid = 1'b0;
        end
        if (lost) m_ovf = 1'b1;
        else if (oc) m_ovf = 1'b0;
    endtask

    task automatic check_model();
        check("valid", 32'(valid), 32'(m_valid));
        check("code", 32'({a, b, c, d}), 32'(m_code));
        check("pend_cnt", 32'(pend_cnt), 32'(count(m_pend)));
        check("overflow", 32'(overflow), 32'(m_ovf));
    endtask

    // One clock: inputs applied before the edge, model advanced, outputs sampled 1ns later.
    task automatic cycle(input logic [15:0] rq, input logic rd, input logic oc);
        req     = rq;
        ready   = rd;
        ovf_clr = oc;
        @(posedge clk);
        model_step(rq, rd, oc);
        #1;
        check_model();
    endtask

    task automatic drain();
        for (int i = 0; i < 20; i++) cycle(16'h0000, 1'b1, 1'b1);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        req      = '0;
        ready    = 1'b0;
        ovf_clr  = 1'b0;
        model_reset();
        #1;
        check("reset_valid", 32'(valid), 32'd0);
        check("reset_code", 32'({a, b, c, d}), 32'd0);
        check("reset_cnt", 32'(pend_cnt), 32'd0);
        check("reset_ovf", 32'(overflow), 32'd0);
        #12 rst_n = 1'b1;
        for (int i = 0; i < 5; i++) cycle(16'h0000, 1'b1, 1'b0);
        check("idle_valid", 32'(valid), 32'd0);

        // Single event
        cycle(16'h0020, 1'b1, 1'b0);
        check("single_cnt1", 32'(pend_cnt), 32'd1);
        cycle(16'h0000, 1'b1, 1'b0);
        check("single_valid", 32'(valid), 32'd1);
        check("single_code", 32'({a, b, c, d}), 32'h5);
        cycle(16'h0000, 1'b1, 1'b0);
        check("single_done", 32'(valid), 32'd0);
        check("single_cnt0", 32'(pend_cnt), 32'd0);

        // Ordering
        cycle(16'h8421, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cycle(16'h0000, 1'b0, 1'b0);
        check("order_hold", 32'({a, b, c, d}), LOW_FIRST ? 32'h0 : 32'hF);
        check("order_cnt", 32'(pend_cnt), 32'd4);
        cycle(16'h0000, 1'b1, 1'b0);
        check("order_2nd", 32'({a, b, c, d}), LOW_FIRST ? 32'h5 : 32'hA);
        cycle(16'h0000, 1'b1, 1'b0);
        check("order_3rd", 32'({a, b, c, d}), LOW_FIRST ? 32'hA : 32'h5);
        cycle(16'h0000, 1'b1, 1'b0);
        check("order_4th", 32'({a, b, c, d}), LOW_FIRST ? 32'hF : 32'h0);
        cycle(16'h0000, 1'b1, 1'b0);
        check("order_end", 32'(valid), 32'd0);

        // Overflow, clear, then req coinciding with accept of the same index
        cycle(16'h0008, 1'b0, 1'b0);
        cycle(16'h0008, 1'b0, 1'b0);
        check("ovf_set", 32'(overflow), 32'd1);
        cycle(16'h0000, 1'b0, 1'b1);
        check("ovf_clr", 32'(overflow), 32'd0);
        check("coin_code", 32'({a, b, c, d}), 32'h3);
        cycle(16'h0008, 1'b1, 1'b0);
        check("coin_no_ovf", 32'(overflow), 32'd0);
        check("coin_cnt", 32'(pend_cnt), 32'd1);
        cycle(16'h0000, 1'b0, 1'b0);
        check("coin_again", 32'({a, b, c, d}), 32'h3);
        check("coin_valid", 32'(valid), 32'd1);
        drain();

        // Hold stability: a higher-priority arrival must not preempt
        cycle(16'h0080, 1'b0, 1'b0);
        cycle(16'h0000, 1'b0, 1'b0);
        cycle(16'h0002, 1'b0, 1'b0);
        cycle(16'h0000, 1'b0, 1'b0);
        check("hold_code", 32'({a, b, c, d}), 32'h7);
        check("hold_cnt", 32'(pend_cnt), 32'd2);
        cycle(16'h0000, 1'b1, 1'b0);
        check("hold_next", 32'({a, b, c, d}), 32'h1);
        drain();

        // Reset mid-operation
        cycle(16'h00F0, 1'b0, 1'b0);
        cycle(16'h0000, 1'b0, 1'b0);
        check("mid_valid_pre", 32'(valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check("mid_valid", 32'(valid), 32'd0);
        check("mid_cnt", 32'(pend_cnt), 32'd0);
        check("mid_code", 32'({a, b, c, d}), 32'd0);
        #3 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) cycle(16'h0000, 1'b0, 1'b0);
        check("mid_after", 32'(valid), 32'd0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic [15:0] rq;
            rq = ($urandom_range(0, 3) == 0) ? 16'($urandom & $urandom & $urandom) : 16'h0000;
            cycle(rq, $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
